multi_cycle_control_unit: RTL and testbench

//  Sequencing FSM for the multi-cycle MIPS-subset CPU. Decodes op/func plus ALU flags and emits per-state control.

---
 rtl/multi_cycle_control_unit_pkg.sv | 103 ++++++++++
 rtl/multi_cycle_control_unit_if.sv | 36 +++
 rtl/multi_cycle_control_unit_decoder.sv | 43 ++++
 rtl/multi_cycle_control_unit.sv | 44 ++++
 tb/tb_multi_cycle_control_unit.sv | 128 ++++++++++++
 5 files changed

// File: rtl/multi_cycle_control_unit_pkg.sv
// cpu_defs_pkg: opcodes, state encodings, control codes and the shared next-state function
// for the multi-cycle MIPS-subset control unit.
package cpu_defs_pkg;

    localparam int OP_W    = 6;
    localparam int STATE_W = 3;
    localparam int ALUOP_W = 3;

    localparam logic [OP_W-1:0] OP_ADD   = 6'b000000;
    localparam logic [OP_W-1:0] OP_SUB   = 6'b000001;
    localparam logic [OP_W-1:0] OP_ADDIU = 6'b000010;
    localparam logic [OP_W-1:0] OP_AND   = 6'b010000;
    localparam logic [OP_W-1:0] OP_ANDI  = 6'b010001;
    localparam logic [OP_W-1:0] OP_ORI   = 6'b010010;
    localparam logic [OP_W-1:0] OP_SLL   = 6'b011000;
    localparam logic [OP_W-1:0] OP_SLT   = 6'b100110;
    localparam logic [OP_W-1:0] OP_SLTI  = 6'b100111;
    localparam logic [OP_W-1:0] OP_SW    = 6'b110000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b110001;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b110100;
    localparam logic [OP_W-1:0] OP_BNE   = 6'b110101;
    localparam logic [OP_W-1:0] OP_BLTZ  = 6'b110110;
    localparam logic [OP_W-1:0] OP_J     = 6'b111000;
    localparam logic [OP_W-1:0] OP_JR    = 6'b111001;
    localparam logic [OP_W-1:0] OP_JAL   = 6'b111010;
    localparam logic [OP_W-1:0] OP_HALT  = 6'b111111;

    localparam logic [ALUOP_W-1:0] ALU_ADD = 3'b000;
    localparam logic [ALUOP_W-1:0] ALU_SUB = 3'b001;
    localparam logic [ALUOP_W-1:0] ALU_SLL = 3'b010;
    localparam logic [ALUOP_W-1:0] ALU_OR  = 3'b011;
    localparam logic [ALUOP_W-1:0] ALU_AND = 3'b100;
    localparam logic [ALUOP_W-1:0] ALU_SLT = 3'b101;

    localparam logic [1:0] PC_NEXT   = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_RS     = 2'b10;
    localparam logic [1:0] PC_JUMP   = 2'b11;

    localparam logic [1:0] RD_RA = 2'b00;
    localparam logic [1:0] RD_RT = 2'b01;
    localparam logic [1:0] RD_RD = 2'b10;

    typedef enum logic [STATE_W-1:0] {
        S_IF     = 3'b000,
        S_ID     = 3'b001,
        S_EXE_LS = 3'b010,
        S_MEM    = 3'b011,
        S_WB_LD  = 3'b100,
        S_EXE_BR = 3'b101,
        S_EXE_AL = 3'b110,
        S_WB_AL  = 3'b111
    } state_e;

    typedef struct packed {
        logic               pc_wre;
        logic               ins_mem_rw;
        logic               ir_wre;
        logic               alu_src_a;
        logic               alu_src_b;
        logic               ext_sel;
        logic [1:0]         reg_dst;
        logic               wr_reg_d_src;
        logic               reg_wre;
        logic               db_data_src;
        logic               m_rd;
        logic               m_wr;
        logic [1:0]         pc_src;
        logic [ALUOP_W-1:0] alu_op;
    } ctrl_t;

    function automatic logic is_alu_r(input logic [OP_W-1:0] op);
        return op == OP_ADD || op == OP_SUB || op == OP_AND || op == OP_SLL || op == OP_SLT;
    endfunction

    function automatic logic is_alu_i(input logic [OP_W-1:0] op);
        return op == OP_ADDIU || op == OP_ANDI || op == OP_ORI || op == OP_SLTI;
    endfunction

    function automatic logic is_ls(input logic [OP_W-1:0] op);
        return op == OP_LW || op == OP_SW;
    endfunction

    function automatic logic is_branch(input logic [OP_W-1:0] op);
        return op == OP_BEQ || op == OP_BNE || op == OP_BLTZ;
    endfunction

    // Shared by the state register and by PCWre, which fires when the next state is IF.
    function automatic state_e next_state(input state_e s, input logic [OP_W-1:0] op);
        case (s)
            S_IF:     return S_ID;
            S_ID:     return op == OP_HALT ? S_ID :
                             is_branch(op) ? S_EXE_BR :
                             is_ls(op)     ? S_EXE_LS :
                             (is_alu_r(op) || is_alu_i(op)) ? S_EXE_AL : S_IF;
            S_EXE_LS: return S_MEM;
            S_MEM:    return op == OP_LW ? S_WB_LD : S_IF;
            S_EXE_AL: return S_WB_AL;
            default:  return S_IF;
        endcase
    endfunction

endpackage

// File: rtl/multi_cycle_control_unit_if.sv
// multi_cycle_control_unit_if: IR/ALU-flag inputs and the datapath control bus of the control unit.
interface multi_cycle_control_unit_if;
    import cpu_defs_pkg::*;

    logic [OP_W-1:0]    op;
    logic               zero;
    logic               sign;
    logic               PCWre;
    logic               InsMemRW;
    logic               IRWre;
    logic               ALUSrcA;
    logic               ALUSrcB;
    logic               ExtSel;
    logic [1:0]         RegDst;
    logic               WrRegDSrc;
    logic               RegWre;
    logic               DBDataSrc;
    logic               mRD;
    logic               mWR;
    logic [1:0]         PCSrc;
    logic [ALUOP_W-1:0] ALUOp;
    logic [STATE_W-1:0] state_o;

    modport master (
        output op, zero, sign,
        input  PCWre, InsMemRW, IRWre, ALUSrcA, ALUSrcB, ExtSel, RegDst, WrRegDSrc,
               RegWre, DBDataSrc, mRD, mWR, PCSrc, ALUOp, state_o
    );

    modport slave (
        input  op, zero, sign,
        output PCWre, InsMemRW, IRWre, ALUSrcA, ALUSrcB, ExtSel, RegDst, WrRegDSrc,
               RegWre, DBDataSrc, mRD, mWR, PCSrc, ALUOp, state_o
    );

endinterface

// File: rtl/multi_cycle_control_unit_decoder.sv
// control_signal_decoder: combinational map of (state, op, zero, sign) to the control bus;
// reset forces every strobe and write enable low.
module control_signal_decoder
    import cpu_defs_pkg::*;
(
    input  logic            i_rst,
    input  state_e          i_state,
    input  logic [OP_W-1:0] i_op,
    input  logic            i_zero,
    input  logic            i_sign,
    output ctrl_t           o_ctrl
);

    logic w_taken;
    logic w_last;

    always_comb begin
        w_taken = (i_op == OP_BEQ && i_zero) || (i_op == OP_BNE && !i_zero) || (i_op == OP_BLTZ && i_sign);
        w_last  = next_state(i_state, i_op) == S_IF;
        o_ctrl.pc_wre       = !i_rst && w_last;
        o_ctrl.ins_mem_rw   = !i_rst && i_state == S_IF;
        o_ctrl.ir_wre       = !i_rst && i_state == S_IF;
        o_ctrl.alu_src_a    = i_op == OP_SLL;
        o_ctrl.alu_src_b    = is_alu_i(i_op) || is_ls(i_op);
        o_ctrl.ext_sel      = i_op == OP_ADDIU || i_op == OP_SLTI || is_ls(i_op) || is_branch(i_op);
        o_ctrl.reg_dst      = i_op == OP_JAL ? RD_RA : is_alu_r(i_op) ? RD_RD : RD_RT;
        o_ctrl.wr_reg_d_src = i_op != OP_JAL;
        o_ctrl.reg_wre      = !i_rst && ((i_state == S_ID && i_op == OP_JAL) || i_state == S_WB_AL || i_state == S_WB_LD);
        o_ctrl.db_data_src  = i_op == OP_LW;
        o_ctrl.m_rd         = !i_rst && i_state == S_MEM && i_op == OP_LW;
        o_ctrl.m_wr         = !i_rst && i_state == S_MEM && i_op == OP_SW;
        o_ctrl.pc_src       = (i_op == OP_J || i_op == OP_JAL) ? PC_JUMP :
                              i_op == OP_JR ? PC_RS :
                              (i_state == S_EXE_BR && w_taken) ? PC_BRANCH : PC_NEXT;
        // bltz compares rs against $0 through a subtract, same as beq/bne.
        o_ctrl.alu_op       = (i_op == OP_SUB || is_branch(i_op)) ? ALU_SUB :
                              i_op == OP_SLL ? ALU_SLL :
                              i_op == OP_ORI ? ALU_OR :
                              (i_op == OP_AND || i_op == OP_ANDI) ? ALU_AND :
                              (i_op == OP_SLT || i_op == OP_SLTI) ? ALU_SLT : ALU_ADD;
    end

endmodule

// File: rtl/multi_cycle_control_unit.sv
// multi_cycle_control_unit: sequencing FSM of the multi-cycle CPU; owns the state register
// and drives the datapath control bus through control_signal_decoder.
module multi_cycle_control_unit
    import cpu_defs_pkg::*;
(
    input  logic                          CLK,
    input  logic                          Reset,
    multi_cycle_control_unit_if.slave     bus
);

    state_e r_state;
    ctrl_t  w_ctrl;

    always_ff @(posedge CLK) begin
        if (Reset) r_state <= S_IF;
        else       r_state <= next_state(r_state, bus.op);
    end

    control_signal_decoder u_dec (
        .i_rst   (Reset),
        .i_state (r_state),
        .i_op    (bus.op),
        .i_zero  (bus.zero),
        .i_sign  (bus.sign),
        .o_ctrl  (w_ctrl)
    );

    assign bus.PCWre     = w_ctrl.pc_wre;
    assign bus.InsMemRW  = w_ctrl.ins_mem_rw;
    assign bus.IRWre     = w_ctrl.ir_wre;
    assign bus.ALUSrcA   = w_ctrl.alu_src_a;
    assign bus.ALUSrcB   = w_ctrl.alu_src_b;
    assign bus.ExtSel    = w_ctrl.ext_sel;
    assign bus.RegDst    = w_ctrl.reg_dst;
    assign bus.WrRegDSrc = w_ctrl.wr_reg_d_src;
    assign bus.RegWre    = w_ctrl.reg_wre;
    assign bus.DBDataSrc = w_ctrl.db_data_src;
    assign bus.mRD       = w_ctrl.m_rd;
    assign bus.mWR       = w_ctrl.m_wr;
    assign bus.PCSrc     = w_ctrl.pc_src;
    assign bus.ALUOp     = w_ctrl.alu_op;
    assign bus.state_o   = r_state;

endmodule

// File: tb/tb_multi_cycle_control_unit.sv
// tb_multi_cycle_control_unit: directed per-cycle vectors; the driver queues the hand-computed
// {state, strobes, control word} for each cycle and a negedge monitor compares them.
module tb_multi_cycle_control_unit;
    import cpu_defs_pkg::*;

    logic CLK = 0;
    logic Reset;
    int   checks = 0;
    int   failures = 0;

    multi_cycle_control_unit_if bus();

    multi_cycle_control_unit dut (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    // Strobes {PCWre, InsMemRW, IRWre, RegWre, mRD, mWR}
    localparam logic [5:0] D_IF   = 6'b011000;
    localparam logic [5:0] D_0    = 6'b000000;
    localparam logic [5:0] D_LAST = 6'b100000;
    localparam logic [5:0] D_WB   = 6'b100100;
    localparam logic [5:0] D_LD   = 6'b000010;
    localparam logic [5:0] D_ST   = 6'b100001;
    // {RegDst, WrRegDSrc, DBDataSrc, PCSrc, ALUSrcA, ALUSrcB, ExtSel, ALUOp}
    localparam logic [11:0] K_ADD = 12'b10_1_0_00_000_000;
    localparam logic [11:0] K_LW  = 12'b01_1_1_00_011_000;
    localparam logic [11:0] K_SW  = 12'b01_1_0_00_011_000;
    localparam logic [11:0] K_BR  = 12'b01_1_0_00_001_001;
    localparam logic [11:0] K_BRT = 12'b01_1_0_01_001_001;
    localparam logic [11:0] K_JAL = 12'b00_0_0_11_000_000;
    localparam logic [11:0] K_JR  = 12'b01_1_0_10_000_000;
    localparam logic [11:0] K_NOP = 12'b01_1_0_00_000_000;

    logic [20:0] exp_q[$];
    string       name_q[$];

    task automatic cyc(input string nm, input logic r, input logic [5:0] o, input logic z, input logic s,
                       input logic [2:0] st, input logic [5:0] d, input logic [11:0] k);
        @(posedge CLK);
        #1;
        Reset   = r;
        bus.op   = o;
        bus.zero = z;
        bus.sign = s;
        exp_q.push_back({st, d, k});
        name_q.push_back(nm);
    endtask

    always @(negedge CLK) begin
        if (exp_q.size() != 0) begin
            logic [20:0] e;
            logic [20:0] a;
            string       nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            a  = {bus.state_o, bus.PCWre, bus.InsMemRW, bus.IRWre, bus.RegWre, bus.mRD, bus.mWR,
                  bus.RegDst, bus.WrRegDSrc, bus.DBDataSrc, bus.PCSrc, bus.ALUSrcA, bus.ALUSrcB,
                  bus.ExtSel, bus.ALUOp};
            checks++;
            if (a !== e) begin
                failures++;
                $display("FAIL %s: got state=%b strobes=%b ctrl=%b, expected state=%b strobes=%b ctrl=%b",
                         nm, a[20:18], a[17:12], a[11:0], e[20:18], e[17:12], e[11:0]);
            end
        end
    end

    initial begin
        Reset = 1;
        bus.op = OP_ADD;
        bus.zero = 0;
        bus.sign = 0;
        cyc("rst2",    1, OP_ADD, 0, 0, 3'b000, D_0,  K_ADD);
        cyc("add_if",  0, OP_ADD, 0, 0, 3'b000, D_IF, K_ADD);
        cyc("add_id",  0, OP_ADD, 0, 0, 3'b001, D_0,  K_ADD);
        cyc("add_exe", 0, OP_ADD, 0, 0, 3'b110, D_0,  K_ADD);
        cyc("add_wb",  0, OP_ADD, 0, 0, 3'b111, D_WB, K_ADD);
        cyc("lw_if",   0, OP_LW,  0, 0, 3'b000, D_IF, K_LW);
        cyc("lw_id",   0, OP_LW,  0, 0, 3'b001, D_0,  K_LW);
        cyc("lw_exe",  0, OP_LW,  0, 0, 3'b010, D_0,  K_LW);
        cyc("lw_mem",  0, OP_LW,  0, 0, 3'b011, D_LD, K_LW);
        cyc("lw_wb",   0, OP_LW,  0, 0, 3'b100, D_WB, K_LW);
        cyc("sw_if",   0, OP_SW,  0, 0, 3'b000, D_IF, K_SW);
        cyc("sw_id",   0, OP_SW,  0, 0, 3'b001, D_0,  K_SW);
        cyc("sw_exe",  0, OP_SW,  0, 0, 3'b010, D_0,  K_SW);
        cyc("sw_mem",  0, OP_SW,  0, 0, 3'b011, D_ST, K_SW);
        cyc("beqt_if", 0, OP_BEQ, 1, 0, 3'b000, D_IF, K_BR);
        cyc("beqt_id", 0, OP_BEQ, 1, 0, 3'b001, D_0,  K_BR);
        cyc("beqt_ex", 0, OP_BEQ, 1, 0, 3'b101, D_LAST, K_BRT);
        cyc("beqn_if", 0, OP_BEQ, 0, 0, 3'b000, D_IF, K_BR);
        cyc("beqn_id", 0, OP_BEQ, 0, 0, 3'b001, D_0,  K_BR);
        cyc("beqn_ex", 0, OP_BEQ, 0, 0, 3'b101, D_LAST, K_BR);
        cyc("bnet_if", 0, OP_BNE, 0, 0, 3'b000, D_IF, K_BR);
        cyc("bnet_id", 0, OP_BNE, 0, 0, 3'b001, D_0,  K_BR);
        cyc("bnet_ex", 0, OP_BNE, 0, 0, 3'b101, D_LAST, K_BRT);
        cyc("bltz_if", 0, OP_BLTZ, 0, 1, 3'b000, D_IF, K_BR);
        cyc("bltz_id", 0, OP_BLTZ, 0, 1, 3'b001, D_0,  K_BR);
        cyc("bltz_ex", 0, OP_BLTZ, 0, 1, 3'b101, D_LAST, K_BRT);
        cyc("jal_if",  0, OP_JAL, 0, 0, 3'b000, D_IF, K_JAL);
        cyc("jal_id",  0, OP_JAL, 0, 0, 3'b001, D_WB, K_JAL);
        cyc("jr_if",   0, OP_JR,  0, 0, 3'b000, D_IF, K_JR);
        cyc("jr_id",   0, OP_JR,  0, 0, 3'b001, D_LAST, K_JR);
        cyc("nop_if",  0, 6'b101010, 0, 0, 3'b000, D_IF, K_NOP);
        cyc("nop_id",  0, 6'b101010, 0, 0, 3'b001, D_LAST, K_NOP);
        cyc("halt_if", 0, OP_HALT, 0, 0, 3'b000, D_IF, K_NOP);
        for (int i = 0; i < 20; i++) cyc("halt_id", 0, OP_HALT, 0, 0, 3'b001, D_0, K_NOP);
        cyc("halt_rst", 1, OP_HALT, 0, 0, 3'b001, D_0, K_NOP);
        cyc("post_rst", 0, OP_SW, 0, 0, 3'b000, D_IF, K_SW);
        cyc("rsw_id",  0, OP_SW,  0, 0, 3'b001, D_0,  K_SW);
        cyc("rsw_exe", 0, OP_SW,  0, 0, 3'b010, D_0,  K_SW);
        cyc("rsw_mem", 1, OP_SW,  0, 0, 3'b011, D_0,  K_SW);
        cyc("rsw_if",  0, OP_ADD, 0, 0, 3'b000, D_IF, K_ADD);
        cyc("rsw_id2", 0, OP_ADD, 0, 0, 3'b001, D_0,  K_ADD);
        for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(negedge CLK);
        #1;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
